rtc_3wire_master: RTL and testbench

- Serial transport engine for the DS1302-style 3-wire RTC interface (CE, SCLK, bidirectional IO).
- Upstream, the time set/get controller presents a command byte (`adress`) and write data (`data`) with a one-cycle `send` strobe.
- This block serialises the transaction, LSB first, and returns `ready`. On reads it also returns `rtc_data`.
- Sits between the controller and the top-level IO pad; the pad tristate is built at top level from `io_out`/`io_oe`.

---
 rtl/rtc_3wire_master_if.sv | 24 ++
 rtl/rtc_3wire_master.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_3wire_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_3wire_master_if.sv
// Controller handshake plus 3-wire pad signals of rtc_3wire_master.
// master = the serial engine, slave = controller / pad side.
interface rtc_3wire_master_if;
  logic       send;
  logic [7:0] adress;
  logic [7:0] data;
  logic       ready;
  logic [7:0] rtc_data;
  logic       ce;
  logic       sclk;
  logic       io_out;
  logic       io_oe;
  logic       io_in;

  modport master (
    input  send, adress, data, io_in,
    output ready, rtc_data, ce, sclk, io_out, io_oe
  );

  modport slave (
    output send, adress, data, io_in,
    input  ready, rtc_data, ce, sclk, io_out, io_oe
  );
endinterface

// File: rtl/rtc_3wire_master.sv
// DS1302-style 3-wire serial transport engine, LSB first, registered pad outputs.
// Optional IO_SYNC_EN: 2-flop synchroniser on io_in (needs HALF_PERIOD >= 4).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready=1, waiting for send
// S_SETUP | ce high, sclk low, command bit 0 on io_out for CE_SETUP
// S_CMD   | 8 command bit periods (low phase then high phase)
// S_WR    | 8 write-data bit periods, io driven
// S_RD    | 8 read low phases (sample on last cycle), 7 high phases
// S_END   | sclk low, ce high for one half period
// S_RECOV | ce low for CE_RECOVERY, then back to idle with ready
module rtc_3wire_master #(
  parameter int HALF_PERIOD = 50,
  parameter int CE_SETUP    = 4,
  parameter int CE_RECOVERY = 4
) (
  input  logic               clk,
  input  logic               rst,
  rtc_3wire_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WR, S_RD, S_END, S_RECOV
  } state_t;

  localparam int MAX_A = (HALF_PERIOD > CE_SETUP) ? HALF_PERIOD : CE_SETUP;
  localparam int MAX_V = (MAX_A > CE_RECOVERY) ? MAX_A : CE_RECOVERY;
  localparam int CNT_W = $clog2(MAX_V + 1);
  localparam logic [CNT_W-1:0] HP_LD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CS_LD = CNT_W'(CE_SETUP - 1);
  localparam logic [CNT_W-1:0] CR_LD = CNT_W'(CE_RECOVERY - 1);

`ifdef IO_SYNC_EN
  localparam int HP_MIN = 4;
`else
  localparam int HP_MIN = 2;
`endif

  generate
    if (HALF_PERIOD < HP_MIN || CE_SETUP < 1 || CE_RECOVERY < 1) begin : g_bad_param
      $error("rtc_3wire_master: HALF_PERIOD/CE_SETUP/CE_RECOVERY below minimum");
    end
  endgenerate

  logic io_smp;
`ifdef IO_SYNC_EN
  logic [1:0] io_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) io_sync <= '0;
    else      io_sync <= {io_sync[0], bus.io_in};
  end
  assign io_smp = io_sync[1];
`else
  assign io_smp = bus.io_in;
`endif

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_dec;
  logic [2:0]       bit_q, bit_n, bit_inc;
  logic             hi_q, hi_n;
  logic [7:0]       cmd_q, cmd_n, dat_q, dat_n, shf_q, shf_n, rtc_q, rtc_n, tx_bits;
  logic             ready_q, ready_n, ce_q, ce_n, sclk_q, sclk_n;
  logic             out_q, out_n, oe_q, oe_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      cmd_q   <= '0;
      dat_q   <= '0;
      shf_q   <= '0;
      rtc_q   <= '0;
      ready_q <= 1'b1;
      ce_q    <= 1'b0;
      sclk_q  <= 1'b0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      hi_q    <= hi_n;
      cmd_q   <= cmd_n;
      dat_q   <= dat_n;
      shf_q   <= shf_n;
      rtc_q   <= rtc_n;
      ready_q <= ready_n;
      ce_q    <= ce_n;
      sclk_q  <= sclk_n;
      out_q   <= out_n;
      oe_q    <= oe_n;
    end
  end

  // Outputs are computed for the next state and registered, so pads never glitch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    hi_n    = hi_q;
    cmd_n   = cmd_q;
    dat_n   = dat_q;
    shf_n   = shf_q;
    rtc_n   = rtc_q;
    ready_n = ready_q;
    ce_n    = ce_q;
    sclk_n  = sclk_q;
    out_n   = out_q;
    oe_n    = oe_q;
    cnt_dec = cnt_q - CNT_W'(1);
    bit_inc = bit_q + 3'd1;
    tx_bits = (state_q == S_WR) ? dat_q : cmd_q;

    case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          cmd_n   = bus.adress;
          dat_n   = bus.data;
          state_n = S_SETUP;
          cnt_n   = CS_LD;
          ready_n = 1'b0;
          ce_n    = 1'b1;
          sclk_n  = 1'b0;
          oe_n    = 1'b1;
          out_n   = bus.adress[0];
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          state_n = S_CMD;
          cnt_n   = HP_LD;
          bit_n   = '0;
          hi_n    = 1'b0;
          out_n   = cmd_q[0];
        end else begin
          cnt_n = cnt_dec;
        end
      end

      S_CMD, S_WR: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_dec;
        end else if (!hi_q) begin
          hi_n   = 1'b1;
          sclk_n = 1'b1;
          cnt_n  = HP_LD;
        end else begin
          hi_n   = 1'b0;
          sclk_n = 1'b0;
          cnt_n  = HP_LD;
          bit_n  = bit_inc;
          if (bit_q != 3'd7) begin
            out_n = tx_bits[bit_inc];
          end else if (state_q == S_WR) begin
            state_n = S_END;
            oe_n    = 1'b0;
          end else if (cmd_q[0]) begin
            state_n = S_RD;
            oe_n    = 1'b0;
          end else begin
            state_n = S_WR;
            out_n   = dat_q[0];
          end
        end
      end

      // No high phase after bit 7: the RTC sees only 15 rising edges on a read.
      S_RD: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_dec;
        end else if (!hi_q) begin
          shf_n[bit_q] = io_smp;
          cnt_n        = HP_LD;
          if (bit_q == 3'd7) begin
            state_n = S_END;
          end else begin
            hi_n   = 1'b1;
            sclk_n = 1'b1;
          end
        end else begin
          hi_n   = 1'b0;
          sclk_n = 1'b0;
          cnt_n  = HP_LD;
          bit_n  = bit_inc;
        end
      end

      S_END: begin
        if (cnt_q == '0) begin
          state_n = S_RECOV;
          ce_n    = 1'b0;
          cnt_n   = CR_LD;
        end else begin
          cnt_n = cnt_dec;
        end
      end

      S_RECOV: begin
        if (cnt_q == '0) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
          if (cmd_q[0]) rtc_n = shf_q;
        end else begin
          cnt_n = cnt_dec;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.ready    = ready_q;
  assign bus.rtc_data = rtc_q;
  assign bus.ce       = ce_q;
  assign bus.sclk     = sclk_q;
  assign bus.io_out   = out_q;
  assign bus.io_oe    = oe_q;

endmodule

// File: tb/tb_rtc_3wire_master.sv
// Randomised bench for rtc_3wire_master: a pin-level RTC model drives io_in and
// transactions are checked against bit streams and latencies derived from the protocol.
module tb_rtc_3wire_master;
`ifdef IO_SYNC_EN
  localparam int HP = 4;
`else
  localparam int HP = 2;
`endif
  localparam int CS = 2;
  localparam int CR = 4;
  localparam int LAT_WR = CS + 32*HP + HP + CR + 1;
  localparam int LAT_RD = CS + 31*HP + HP + CR + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rtc_3wire_master_if bus();

  rtc_3wire_master #(.HALF_PERIOD(HP), .CE_SETUP(CS), .CE_RECOVERY(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor and RTC read-data model.
  logic [7:0] rtc_byte = 8'h00;
  bit  out_q[$];
  bit  oe_q[$];
  int  gap_q[$];
  int  hirun_q[$];
  int  viol = 0;
  int  ready_falls = 0;
  int  x_rise = 0;
  int  low_run = 0;
  int  hi_run = 0;
  bit  p_sclk = 1'b0;
  bit  p_ce = 1'b0;
  bit  p_ready = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      bus.io_in <= 1'b0;
    end else begin
      if (bus.sclk && !p_sclk) begin
        out_q.push_back(bus.io_out);
        oe_q.push_back(bus.io_oe);
        x_rise <= x_rise + 1;
      end
      if (!bus.sclk && p_sclk && x_rise >= 8 && x_rise <= 15)
        bus.io_in <= rtc_byte[x_rise-8];
      if (bus.ce != p_ce && (bus.sclk || p_sclk)) viol <= viol + 1;
      if (bus.io_oe && !bus.ce) viol <= viol + 1;
      if (bus.ce && !p_ce) begin
        gap_q.push_back(low_run);
        x_rise <= 0;
      end
      if (p_ready && !bus.ready) begin
        ready_falls <= ready_falls + 1;
        hirun_q.push_back(hi_run);
      end
    end
    low_run <= bus.ce ? 0 : low_run + 1;
    hi_run  <= bus.ready ? hi_run + 1 : 0;
    p_sclk  <= bus.sclk;
    p_ce    <= bus.ce;
    p_ready <= bus.ready;
  end

  logic [7:0] model_rtc = 8'h00;

  task automatic xfer(input logic [7:0] adr, input logic [7:0] dat, input logic [7:0] rb,
                      input int busy_at, input string tag);
    int s_out, s_fall, c0, lat, n_rise;
    logic [15:0] got_b, got_oe;
    rtc_byte = rb;
    s_out    = out_q.size();
    s_fall   = ready_falls;
    @(negedge clk);
    bus.adress = adr;
    bus.data   = dat;
    bus.send   = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.send = 1'b0;
    lat = -1;
    for (int i = 1; i < 3000; i++) begin
      bus.send = (i == busy_at);
      if (i == busy_at) begin
        bus.adress = ~adr;
        bus.data   = ~dat;
      end
      if (bus.ready) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    bus.send = 1'b0;
    if (adr[0]) model_rtc = rb;
    chk($sformatf("%s_latency", tag), lat, adr[0] ? LAT_RD : LAT_WR);
    @(negedge clk);
    n_rise = out_q.size() - s_out;
    got_b  = '0;
    got_oe = '0;
    for (int j = 0; j < 16; j++) begin
      if (s_out + j < out_q.size()) begin
        got_b[j]  = out_q[s_out+j];
        got_oe[j] = oe_q[s_out+j];
      end
    end
    chk($sformatf("%s_rises", tag), n_rise, adr[0] ? 15 : 16);
    if (adr[0]) begin
      chk($sformatf("%s_cmd_bits", tag), got_b[7:0], adr);
      chk($sformatf("%s_oe", tag), got_oe, 16'h00FF);
    end else begin
      chk($sformatf("%s_bits", tag), got_b, {dat, adr});
      chk($sformatf("%s_oe", tag), got_oe, 16'hFFFF);
    end
    chk($sformatf("%s_rtc_data", tag), bus.rtc_data, model_rtc);
    chk($sformatf("%s_ready_falls", tag), ready_falls - s_fall, 1);
    chk($sformatf("%s_idle_pins", tag), {bus.ready, bus.ce, bus.sclk, bus.io_oe}, 4'b1000);
    chk($sformatf("%s_invariants", tag), viol, 0);
  endtask

  task automatic b2b(input logic [7:0] adr, input logic [7:0] dat);
    int s_f, s_out, s_gap, s_hr, t;
    logic [15:0] got_b;
    s_f   = ready_falls;
    s_out = out_q.size();
    s_gap = gap_q.size();
    s_hr  = hirun_q.size();
    @(negedge clk);
    bus.adress = adr;
    bus.data   = dat;
    bus.send   = 1'b1;
    t = 0;
    while (ready_falls < s_f + 3 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    bus.send = 1'b0;
    t = 0;
    while (!bus.ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("b2b_ready_falls", ready_falls - s_f, 3);
    chk("b2b_rises", out_q.size() - s_out, 48);
    for (int k = 0; k < 3; k++) begin
      got_b = '0;
      for (int j = 0; j < 16; j++)
        if (s_out + 16*k + j < out_q.size()) got_b[j] = out_q[s_out+16*k+j];
      chk($sformatf("b2b_bits%0d", k), got_b, {dat, adr});
    end
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("b2b_ce_gap%0d", k),
          (gap_q.size() > s_gap + k) ? (gap_q[s_gap+k] >= CR) : 1'b0, 1);
      chk($sformatf("b2b_ready_hi%0d", k),
          (hirun_q.size() > s_hr + k) ? hirun_q[s_hr+k] : -1, 1);
    end
    chk("b2b_rtc_data", bus.rtc_data, model_rtc);
    chk("b2b_invariants", viol, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s_out, busy;
    logic [7:0] a, d, r;
    bus.send   = 1'b0;
    bus.adress = 8'h00;
    bus.data   = 8'h00;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_rtc_data", bus.rtc_data, 8'h00);
    chk("reset_pins", {bus.ce, bus.sclk, bus.io_out, bus.io_oe}, 4'b0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    xfer(8'h80, 8'hA5, 8'h00, -1, "write");
    xfer(8'h81, 8'h00, 8'h37, -1, "read");
    xfer(8'h8E, 8'h3C, 8'h00, 20, "busy_wr");
    xfer(8'h85, 8'h00, 8'hE1, 33, "busy_rd");
    b2b(8'h90, 8'h6B);

    for (int n = 0; n < 8; n++) begin
      a    = 8'($urandom);
      d    = 8'($urandom);
      r    = 8'($urandom);
      busy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 60)) : -1;
      xfer(a, d, r, busy, $sformatf("rand%0d", n));
    end
    xfer(8'h83, 8'h00, 8'h6C, -1, "read_pre_reset");

    rtc_byte = 8'hC3;
    s_out = out_q.size();
    @(negedge clk);
    bus.adress = 8'h8B;
    bus.send   = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    t = 0;
    while (out_q.size() < s_out + 10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reached_rd", out_q.size() - s_out, 10);
    #2 rst = 1'b0;
    #1;
    chk("rst_pins", {bus.ce, bus.sclk, bus.io_oe}, 3'b000);
    chk("rst_ready", bus.ready, 1);
    chk("rst_rtc_data", bus.rtc_data, 8'h00);
    model_rtc = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(8'h81, 8'h00, 8'h5A, -1, "read_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
